// File: rtl/morph_pkg.sv
// rtl/morph_pkg.sv - shared types and constants for the 3x3 binary morphology window controller
package morph_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_FILL,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int V_ACTIVE_DEF = 768;

    localparam int WIN_ROWS = 3;
    localparam int WIN_COLS = 3;
    localparam int WIN_W    = WIN_ROWS * WIN_COLS;

    // Row 0 is the oldest line, column 0 the leftmost pixel.
    function automatic int win_bit(input int r, input int c);
        return r * WIN_COLS + c;
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/line_buf_1b.sv
// rtl/line_buf_1b.sv - 1-bit line buffer, one write port, one registered read port
module line_buf_1b #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_data
);

    logic mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/morph_window_ctrl.sv
// rtl/morph_window_ctrl.sv - rotates three line buffers and emits 3x3 binary windows per frame
module morph_window_ctrl
    import morph_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [10:0]      hcount,
    input  logic [9:0]       vcount,
    input  logic             pixel_in,
    output logic [WIN_W-1:0] win,
    output logic             win_valid,
    output logic [10:0]      win_h,
    output logic [9:0]       win_v,
    output logic             busy,
    output logic             frame_done
);

    localparam int          AW      = (H_ACTIVE > 2) ? $clog2(H_ACTIVE) : 1;
    localparam logic [10:0] H_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [10:0] H_CLAST = 11'(H_ACTIVE - 2);
    localparam logic [9:0]  V_CLAST = 10'(V_ACTIVE - 2);

    state_t           state;
    logic [1:0]       wp;
    logic [1:0]       wsel;
    logic [1:0]       wp1;
    logic             active;
    logic             frame_start;
    logic             restart;
    logic             writing;
    logic             line_end;
    logic [2:0]       rd_data;
    logic             act1;
    logic             valid1;
    logic             pix1;
    logic [10:0]      h1;
    logic [9:0]       v1;
    logic [2:0]       col0;
    logic [2:0]       col1;
    logic [2:0]       col_cur;
    logic [WIN_W-1:0] win_next;

    assign active      = (hcount <= H_LAST) && (vcount <= V_LAST);
    assign frame_start = (hcount == 11'd0) && (vcount == 10'd0);
    assign restart     = frame_start && ((state == ST_FILL) || (state == ST_RUN));
    assign writing     = active && ((state == ST_FILL) || (state == ST_RUN) ||
                                    ((state == ST_ARM) && enable && frame_start));
    // A frame start always lands in buffer 0, whatever wp held before.
    assign wsel        = frame_start ? 2'd0 : wp;
    assign line_end    = writing && (hcount == H_LAST);

    for (genvar i = 0; i < 3; i++) begin : g_lb
        line_buf_1b #(.DEPTH(H_ACTIVE), .AW(AW)) u_lb (
            .clock   (clock),
            .wr_en   (writing && (wsel == 2'(i))),
            .wr_addr (hcount[AW-1:0]),
            .wr_data (pixel_in),
            .rd_addr (hcount[AW-1:0]),
            .rd_data (rd_data[i])
        );
    end

    // Buffer after the write pointer holds line v-2, the one after that line v-1.
    assign col_cur = {pix1, rd_data[ptr_inc(ptr_inc(wp1))], rd_data[ptr_inc(wp1)]};

    always_comb begin
        win_next = '0;
        for (int r = 0; r < WIN_ROWS; r++) begin
            win_next[win_bit(r, 0)] = col0[r];
            win_next[win_bit(r, 1)] = col1[r];
            win_next[win_bit(r, 2)] = col_cur[r];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            wp         <= 2'd0;
            wp1        <= 2'd0;
            act1       <= 1'b0;
            valid1     <= 1'b0;
            pix1       <= 1'b0;
            h1         <= '0;
            v1         <= '0;
            col0       <= '0;
            col1       <= '0;
            win        <= '0;
            win_valid  <= 1'b0;
            win_h      <= '0;
            win_v      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            win_valid  <= 1'b0;
            act1       <= writing;
            valid1     <= 1'b0;

            if (writing) begin
                pix1   <= pixel_in;
                h1     <= hcount;
                v1     <= vcount;
                wp1    <= wsel;
                wp     <= line_end ? ptr_inc(wsel) : wsel;
                valid1 <= (state == ST_RUN) && !restart &&
                          (hcount >= 11'd2) && (vcount >= 10'd2);
            end

            if (act1) begin
                col0 <= col1;
                col1 <= col_cur;
            end

            if (valid1 && (state == ST_RUN) && !restart) begin
                win_valid <= 1'b1;
                win       <= win_next;
                win_h     <= h1 - 11'd1;
                win_v     <= v1 - 10'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_ARM;
                        busy  <= 1'b1;
                    end
                end
                ST_ARM: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (frame_start) begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (!restart && line_end && (vcount == 10'd1)) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (restart) begin
                        state <= ST_FILL;
                    end else if (win_valid && (win_h == H_CLAST) && (win_v == V_CLAST)) begin
                        state      <= ST_DONE;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state <= enable ? ST_ARM : ST_IDLE;
                    busy  <= enable;
                end
            endcase
        end
    end

endmodule
